// File: rtl/serial_addsub_nand_if.sv
// Operand/result bundle for the bit-serial add/sub unit.
//   master: drives start, sub, a, b; observes busy, done, sum, cout, ovf
//   slave : the arithmetic unit itself
interface serial_addsub_nand_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b,
                  input  busy, done, sum, cout, ovf);
  modport slave  (input  start, sub, a, b,
                  output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub_nand.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of serial_addsub_nand_if
//          (start/sub/a/b in; busy/done/sum/cout/ovf out)
// A start accepted at edge k yields a one-cycle done after edge k+WIDTH.
// Results are only written on the last RUN edge, so sum/cout/ovf never
// show partial values while busy.

// One full-adder slice with optional b inversion, nand gates only.
module serial_addsub_nand_cell (
  input  wire a,
  input  wire b,
  input  wire sub,
  input  wire cin,
  output wire s,
  output wire cout
);
  wire n1, n2, n3, bp;
  wire m1, m2, m3, x;
  wire k1, k2, k3;

  // bp = b ^ sub
  nand g_n1 (n1, b, sub);
  nand g_n2 (n2, b, n1);
  nand g_n3 (n3, sub, n1);
  nand g_bp (bp, n2, n3);

  // x = a ^ bp; m1 doubles as ~(a & bp) for the carry
  nand g_m1 (m1, a, bp);
  nand g_m2 (m2, a, m1);
  nand g_m3 (m3, bp, m1);
  nand g_x  (x, m2, m3);

  // s = x ^ cin; k1 doubles as ~(x & cin) for the carry
  nand g_k1 (k1, x, cin);
  nand g_k2 (k2, x, k1);
  nand g_k3 (k3, cin, k1);
  nand g_s  (s, k2, k3);

  // cout = (a & bp) | (x & cin) == majority(a, bp, cin)
  nand g_co (cout, m1, k1);
endmodule

module serial_addsub_nand #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_addsub_nand_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, sum_r;
  logic             sub_r, c, cout_r, ovf_r;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nxt, accept, last;

  serial_addsub_nand_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .sub  (sub_r),
    .cin  (c),
    .s    (s_bit),
    .cout (c_nxt)
  );

  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      sum_r  <= '0;
      sub_r  <= 1'b0;
      c      <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      sub_r  <= bus.sub;
      c      <= bus.sub;   // +1 of the two's-complement negate
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {s_bit, res_sr[WIDTH-1:1]};
      c      <= c_nxt;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        // c is still the carry into the MSB on this edge
        sum_r  <= {s_bit, res_sr[WIDTH-1:1]};
        cout_r <= c_nxt;
        ovf_r  <= c ^ c_nxt;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: doc/serial_addsub_nand.md
SERIAL_ADDSUB_NAND -- requirements
Module: serial_addsub_nand

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation on a, b, sub.
REQ-005 SHALL have port sub  input  1  mode select: 0 = a+b, 1 = a-b.
REQ-006 SHALL have port a  input  WIDTH  first operand, sampled only when start is accepted.
REQ-007 SHALL have port b  input  WIDTH  second operand, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port sum  output  WIDTH  result, a+b or a-b modulo 2^WIDTH.
REQ-011 SHALL have port cout  output  1  final carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 SHALL be a bit-serial adder/subtractor with three states: IDLE, RUN, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start SHALL be ignored in RUN.
REQ-015 On an accepted start, SHALL load a, b and sub into shift/mode registers.
REQ-016 On an accepted start, SHALL preset the carry flop to sub and clear the bit counter, then enter RUN.
REQ-017 In RUN, SHALL process one bit per clock, LSB first.
REQ-018 In RUN, each bit SHALL be s_i = a_i XOR b'_i XOR c, with b'_i = b_i XOR sub.
REQ-019 In RUN, the carry flop SHALL load c <= majority(a_i, b'_i, c) each clock.
REQ-020 In RUN, s_i SHALL shift into the result register from the MSB end.
REQ-021 The per-bit combinational cell (b inversion, sum, carry) SHALL be built only from nand primitives: no operators, no procedural logic.
REQ-022 Procedural blocks SHALL be limited to flops and the state register.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide.
REQ-024 After exactly WIDTH RUN cycles, SHALL enter DONE.
REQ-025 Latency: if start is sampled at edge k, done SHALL be high during the cycle after edge k+WIDTH, for exactly one cycle.
REQ-026 busy SHALL be high exactly in RUN.
REQ-027 On entering DONE, SHALL update sum, cout and ovf together.
REQ-028 ovf SHALL be computed from the carry into the MSB, captured on the last RUN cycle, and the final carry.
REQ-029 sum, cout and ovf SHALL hold their values until the next DONE entry or reset; they SHALL NOT show partial results while busy.
REQ-030 DONE SHALL return to IDLE on the next edge unless start is high, in which case it SHALL go directly to RUN (back-to-back operations, no idle bubble).
REQ-031 If start and rst are both high on the same edge, rst SHALL win.

Reset
REQ-032 On rst high at a clock edge, SHALL go to IDLE and clear busy, done, sum, cout, ovf, carry, counter and operand registers to 0.
REQ-033 A reset during RUN SHALL abort the operation with no done pulse; the next accepted start SHALL behave as from power-up.

Verification
REQ-034 Bench SHALL check, with WIDTH=8: add 0x0F+0x01 -> sum=0x10, cout=0, ovf=0; done exactly 8 edges after start edge; busy high 8 cycles.
REQ-035 Bench SHALL check: add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0; add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
REQ-036 Bench SHALL check: sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-037 Bench SHALL check: start with a=0x33 pulsed again mid-RUN with a=0xAA -> ignored; result from the first operands only.
REQ-038 Bench SHALL check: rst at RUN cycle 4 -> no done, all outputs 0; then 0x02+0x03 -> sum=0x05.
REQ-039 Bench SHALL run back-to-back starts held high through DONE, plus an exhaustive sweep at WIDTH=2 (all a, b, sub), against a behavioural model.
